rv32i_reg_file: RTL and testbench
=================================

// Module: rv32i_reg_file
//
// PURPOSE
// - RV32I integer register file: 32 x 32-bit general-purpose registers (x0..x31).
// - Two asynchronous (combinational) read ports and one synchronous write port.
// - Sits in the decode stage of the core: rs1/rs2 operands are read here, and the
//   rd result is written back here.
// - x0 is hardwired to zero.
//
// PARAMETERS
// - DATA_WIDTH  32  register width in bits (XLEN)
// - NUM_REGS    32  number of architectural registers
// - ADDR_WIDTH  5   register index width, equal to $clog2(NUM_REGS)
//
// PORTS
// - clk        in   1           single clock; all state updates on its rising edge
// - rst_n      in   1           asynchronous, active-low reset
// - wr_en      in   1           write enable
// - wr_reg     in   ADDR_WIDTH  write register index (rd)
// - wr_data    in   DATA_WIDTH  write data
// - rd_reg_1   in   ADDR_WIDTH  read port 1 register index (rs1)
// - rd_reg_2   in   ADDR_WIDTH  read port 2 register index (rs2)
// - rd_data_1  out  DATA_WIDTH  read port 1 data
// - rd_data_2  out  DATA_WIDTH  read port 2 data
//
// BEHAVIOUR
// - Reset: rst_n low immediately clears all registers x1..x31 to 0.
//   - Independent of clk; reset is asynchronous.
//   - The clear holds while rst_n stays low, and writes are ignored during that time.
//   - Read outputs reflect the cleared state combinationally.
// - Write: at posedge clk, if rst_n is high, wr_en is 1 and wr_reg != 0, the
//   register at wr_reg is loaded with wr_data.
//   - Single-cycle write latency; no handshake.
// - Writes to x0 are silently discarded. x0 always reads 32'h0000_0000.
// - wr_en = 0: no register changes, regardless of wr_reg and wr_data.
// - Reads: rd_data_N = regs[rd_reg_N], purely combinational, with zero-cycle latency.
//   - Outputs must settle within the same cycle after any change of rd_reg_N.
// - Both read ports are fully independent.
//   - They may address the same register simultaneously and both return the same value.
// - Read-during-write (same index, same cycle), without bypass:
//   - The read returns the OLD stored value until the capturing clock edge.
//   - The new value is visible immediately after that edge.
// - No X propagation: every register has a defined value after reset.
//
// CONFIGURATION
// - REG_FILE_BYPASS_EN defined: adds write-to-read forwarding.
//   - If wr_en = 1, wr_reg != 0 and rd_reg_N == wr_reg, then rd_data_N = wr_data
//     combinationally, in the same cycle as the write.
//   - Reads of x0 still return 0.
// - REG_FILE_BYPASS_EN undefined (default): no forwarding.
//   - Read-during-write returns the old value, as described under BEHAVIOUR.
//
// TESTING
// - Bench drives inputs right after posedge clk and samples reads about 3 ns later.
//   Every read is checked against a reference model.
// - Reset: assert rst_n = 0 mid-run, then release. Reads of any x1..x31 -> 0.
// - x0 protection: write wr_reg = 0, wr_data = 32'hFFFF_FFFF, wr_en = 1, then read
//   rd_reg_1 = 0 -> 0.
// - Write/readback: write x5 = 32'hDEAD_BEEF. In the same cycle, read rd_reg_1 = 5
//   -> old value (0). In the next cycle, read both ports at 5 -> 32'hDEAD_BEEF.
// - Write disable: wr_en = 0, wr_reg = 7, wr_data = 32'h1234_5678. Read x7 next
//   cycle -> unchanged value.
// - Dual read: x1 = 32'h1, x31 = 32'h8000_0000. Set rd_reg_1 = 1 and rd_reg_2 = 31
//   -> 32'h1 and 32'h8000_0000 respectively.
// - Random: 1000 constrained-random transactions scored against the model.
//   Cover all wr_reg/rd_reg values, wr_en in both states, and read-during-write
//   on the same index.

Source files
------------

// File: rtl/rv32i_reg_file.sv
// RV32I integer register file: 32 x XLEN registers, two combinational read ports, one write port.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module rv32i_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is a constant; it is never selected for writing.
        assign wr_sel[gi] = 1'b0;
        assign regs_d[gi] = '0;
      end else begin : g_gpr
        assign wr_sel[gi] = wr_en && (wr_reg == ADDR_WIDTH'(gi));
        assign regs_d[gi] = wr_sel[gi] ? wr_data : regs_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data_1 = '0;
    if (rd_reg_1 != '0 && int'(rd_reg_1) < NUM_REGS) begin
      rd_data_1 = regs_q[rd_reg_1];
    end
`ifdef REG_FILE_BYPASS_EN
    // wr_reg != 0 keeps x0 reads at zero even when forwarding.
    if (wr_en && wr_reg != '0 && rd_reg_1 == wr_reg) begin
      rd_data_1 = wr_data;
    end
`endif
  end

  always_comb begin
    rd_data_2 = '0;
    if (rd_reg_2 != '0 && int'(rd_reg_2) < NUM_REGS) begin
      rd_data_2 = regs_q[rd_reg_2];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && wr_reg != '0 && rd_reg_2 == wr_reg) begin
      rd_data_2 = wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_rv32i_reg_file.sv
// Directed and randomized checks of rv32i_reg_file against a simple array reference model.
// Honours REG_FILE_BYPASS_EN when computing expected same-cycle read data.
module tb_rv32i_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  int n_cmp;
  int n_err;

  logic [31:0] model [32];

  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] RDW_BEEF = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] RDW_BEEF = 32'h0000_0000;
`endif

  rv32i_reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read data for index r given the current model and driven write inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] r);
    logic [31:0] v;
    v = (r == 5'd0) ? 32'h0 : model[r];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && wr_reg != 5'd0 && r == wr_reg) v = wr_data;
`endif
    return v;
  endfunction

  // Drive one cycle: inputs 1 ns after posedge, sample point 3 ns later.
  // The model is advanced afterwards since the next posedge captures these inputs.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    wr_en    = we;
    wr_reg   = wa;
    wr_data  = wd;
    rd_reg_1 = r1;
    rd_reg_2 = r2;
    #3;
  endtask

  task automatic commit();
    if (rst_n && wr_en && wr_reg != 5'd0) model[wr_reg] = wr_data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_reg   = 5'd0;
    wr_data  = 32'h0;
    rd_reg_1 = 5'd3;
    rd_reg_2 = 5'd17;
    clear_model();

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("reset_rd1_x3", rd_data_1, 32'h0);
    check("reset_rd2_x17", rd_data_2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // x0 protection
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("x0_same_cycle", rd_data_1, 32'h0);
    commit();
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("x0_after_rd1", rd_data_1, 32'h0);
    check("x0_after_rd2", rd_data_2, 32'h0);
    commit();

    // Write/readback with read-during-write
    step(1'b1, 5'd5, BEEF, 5'd5, 5'd0);
    check("x5_rdw", rd_data_1, RDW_BEEF);
    commit();
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("x5_rd1", rd_data_1, BEEF);
    check("x5_rd2", rd_data_2, BEEF);
    commit();

    // Write disable
    step(1'b1, 5'd7, 32'h0BAD_F00D, 5'd0, 5'd0);
    commit();
    step(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
    check("x7_wr_dis_same", rd_data_1, 32'h0BAD_F00D);
    commit();
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    check("x7_wr_dis_next", rd_data_1, 32'h0BAD_F00D);
    check("x5_still", rd_data_2, BEEF);
    commit();

    // Dual read of the boundary registers
    step(1'b1, 5'd1, 32'h0000_0001, 5'd0, 5'd0);
    commit();
    step(1'b1, 5'd31, 32'h8000_0000, 5'd0, 5'd0);
    commit();
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    check("dual_x1", rd_data_1, 32'h0000_0001);
    check("dual_x31", rd_data_2, 32'h8000_0000);
    commit();

    // Asynchronous reset mid-cycle, with a write attempt while held
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x5", rd_data_1, 32'h0);
    check("async_rst_x31", rd_data_2, 32'h0);
    clear_model();
    wr_en   = 1'b1;
    wr_reg  = 5'd9;
    wr_data = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    rd_reg_1 = 5'd9;
    rd_reg_2 = 5'd7;
    #1;
    check("rst_hold_x9", rd_data_1, 32'h0);
    check("rst_hold_x7", rd_data_2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5'd9, 32'h1357_9BDF, 5'd1, 5'd5);
    check("post_rst_x1", rd_data_1, 32'h0);
    check("post_rst_x5", rd_data_2, 32'h0);
    commit();
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    check("post_rst_x9", rd_data_1, 32'h1357_9BDF);
    check("post_rst_x0", rd_data_2, 32'h0);
    commit();

    // Randomized traffic scored against the model
    for (int i = 0; i < 1000; i++) begin
      logic        we;
      logic [4:0]  wa;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      wa = 5'(i % 32);
      wd = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'((i * 7) % 32);
      step(we, wa, wd, r1, r2);
      check("rand_rd1", rd_data_1, exp_rd(r1));
      check("rand_rd2", rd_data_2, exp_rd(r2));
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
